// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: multi-cycle execute sequencer for RV32I ALU instructions.
// Accepts one instruction word, decodes R-type and I-type arithmetic,
// reads the external register file, drives the external combinational ALU
// and writes the result back. One instruction is in flight at a time.
module alu_exec_ctrl #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output logic [RF_AW-1:0] rf_raddr1,
  output logic [RF_AW-1:0] rf_raddr2,
  input  logic [XLEN-1:0]  rf_rdata1,
  input  logic [XLEN-1:0]  rf_rdata2,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [3:0]       alu_op,
  input  logic [XLEN-1:0]  alu_result,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             done,
  output logic             illegal,
  output logic [XLEN-1:0]  retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_FAULT
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9
  } alu_op_t;

  localparam logic [6:0] OPC_REG = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  state_t          state_q, state_d;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] alu_a_q, alu_b_q, res_q, retire_q;
  alu_op_t         alu_op_q;

  // Decode results, only meaningful while in DECODE.
  logic            dec_legal;
  alu_op_t         dec_op;
  logic [XLEN-1:0] dec_b;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_sext, shamt_zext;

  assign opcode     = ir_q[6:0];
  assign rd         = ir_q[11:7];
  assign funct3     = ir_q[14:12];
  assign funct7     = ir_q[31:25];
  assign imm_sext   = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign shamt_zext = {{(XLEN-5){1'b0}}, ir_q[24:20]};

  assign rf_raddr1  = RF_AW'(ir_q[19:15]);
  assign rf_raddr2  = RF_AW'(ir_q[24:20]);
  assign rf_waddr   = RF_AW'(rd);
  assign rf_wdata   = res_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign retire_cnt = retire_q;

  // Instruction decode: legality, ALU operation and operand B source.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    dec_legal = 1'b0;
    dec_op    = OP_ADD;
    dec_b     = rf_rdata2;
    case (opcode)
      OPC_REG: begin
        dec_legal = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: dec_op = OP_ADD;
          {F7_ALT,  3'b000}: dec_op = OP_SUB;
          {F7_BASE, 3'b001}: dec_op = OP_SLL;
          {F7_BASE, 3'b010}: dec_op = OP_SLT;
          {F7_BASE, 3'b011}: dec_op = OP_SLTU;
          {F7_BASE, 3'b100}: dec_op = OP_XOR;
          {F7_BASE, 3'b101}: dec_op = OP_SRL;
          {F7_ALT,  3'b101}: dec_op = OP_SRA;
          {F7_BASE, 3'b110}: dec_op = OP_OR;
          {F7_BASE, 3'b111}: dec_op = OP_AND;
          default:           dec_legal = 1'b0;
        endcase
      end
      OPC_IMM: begin
        dec_legal = 1'b1;
        dec_b     = imm_sext;
        case (funct3)
          3'b000: dec_op = OP_ADD;
          3'b010: dec_op = OP_SLT;
          3'b011: dec_op = OP_SLTU;
          3'b100: dec_op = OP_XOR;
          3'b110: dec_op = OP_OR;
          3'b111: dec_op = OP_AND;
          3'b001: begin
            dec_op    = OP_SLL;
            dec_b     = shamt_zext;
            dec_legal = (funct7 == F7_BASE);
          end
          default: begin
            // funct3 101: logical or arithmetic right shift by shamt.
            dec_b = shamt_zext;
            if (funct7 == F7_BASE) begin
              dec_op = OP_SRL;
            end else if (funct7 == F7_ALT) begin
              dec_op = OP_SRA;
            end else begin
              dec_legal = 1'b0;
            end
          end
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state logic and state-decoded handshake/writeback strobes.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    rf_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: state_d = dec_legal ? S_EXEC : S_FAULT;
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        done    = 1'b1;
        rf_we   = (rd != 5'd0);
        state_d = S_IDLE;
      end
      S_FAULT: begin
        done    = 1'b1;
        illegal = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Datapath registers: instruction capture, operand latch, result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OP_ADD;
      res_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid) ir_q <= instr;
        end
        S_DECODE: begin
          if (dec_legal) begin
            alu_a_q  <= rf_rdata1;
            alu_b_q  <= dec_b;
            alu_op_q <= dec_op;
          end
        end
        S_EXEC:  res_q <= alu_result;
        default: ;
      endcase
    end
  end

  // Retire counter: reloaded every cycle, adding one in WB; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= '0;
    end else begin
      retire_q <= retire_q + {{(XLEN-1){1'b0}}, (state_q == S_WB)};
    end
  end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Multi-cycle execute sequencer for the RV32I integer ALU.
- Accepts one 32-bit instruction word through a valid/ready handshake and decodes R-type (opcode 0110011) and I-type arithmetic (opcode 0010011).
- Reads operands from the external register file, drives the external combinational ALU, and writes the result back.
- Sits between the fetch stage and the ALU/register-file datapath; one instruction in flight at a time.

Parameters:
XLEN, 32, datapath width of operands, result and retire counter
RF_AW, 5, register-file address width

Ports:
clk  in  1  clock, all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction word on instr is valid
instr  in  32  RV32 instruction word
instr_ready  out  1  controller can accept an instruction
rf_raddr1  out  RF_AW  read address, rs1 = ir[19:15]
rf_raddr2  out  RF_AW  read address, rs2 = ir[24:20]
rf_rdata1  in  XLEN  combinational read data for rf_raddr1
rf_rdata2  in  XLEN  combinational read data for rf_raddr2
alu_a  out  XLEN  ALU operand A (registered)
alu_b  out  XLEN  ALU operand B (registered)
alu_op  out  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA
alu_result  in  XLEN  combinational ALU result
rf_we  out  1  register-file write strobe
rf_waddr  out  RF_AW  write address, rd = ir[11:7]
rf_wdata  out  XLEN  write data
done  out  1  one-cycle pulse when an instruction retires or faults
illegal  out  1  qualifies done: instruction not supported, no write performed
retire_cnt  out  XLEN  count of successfully retired instructions

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - ir, alu_a, alu_b, alu_op, res, retire_cnt all 0.
  - rf_we=0, done=0, illegal=0.
  - Reset asserted mid-instruction abandons it with no write and no done.
- States: IDLE, DECODE, EXEC, WB, FAULT.
- IDLE:
  - instr_ready=1; in all other states instr_ready=0.
  - On instr_valid&instr_ready: ir<=instr, go to DECODE.
  - instr_valid while busy is ignored; the word is not consumed.
- DECODE:
  - rf_raddr1/2 are driven from ir in every state.
  - Legal instruction: alu_a<=rf_rdata1, alu_op<=decoded op, go to EXEC.
  - alu_b<=rf_rdata2 for R-type; for I-type alu_b<=sign-extended ir[31:20], except shifts, which use zero-extended shamt ir[24:20].
  - Illegal instruction: go to FAULT.
- R-type decode (funct7/funct3):
  - 0000000/000 ADD, 0100000/000 SUB, 0000000/001 SLL, 0000000/010 SLT, 0000000/011 SLTU.
  - 0000000/100 XOR, 0000000/101 SRL, 0100000/101 SRA, 0000000/110 OR, 0000000/111 AND.
  - Any other combination is illegal.
- I-type decode (funct3):
  - 000 ADDI, 010 SLTI, 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI.
  - 001 SLLI only with ir[31:25]=0000000.
  - 101 SRLI with ir[31:25]=0000000, or SRAI with ir[31:25]=0100000.
  - Otherwise illegal. Any other opcode is illegal.
- EXEC: res<=alu_result, go to WB.
- WB:
  - done=1, rf_waddr=rd, rf_wdata=res.
  - rf_we=1 only if rd!=0; writes to x0 are suppressed but still retire.
  - retire_cnt increments by 1, wrapping from 2^XLEN-1 to 0. Go to IDLE.
- FAULT: done=1, illegal=1, rf_we=0, retire_cnt unchanged, go to IDLE.
- Latency:
  - Handshake at edge 0 gives DECODE in cycle 1, EXEC in cycle 2, WB with done in cycle 3.
  - The next instruction can be accepted in cycle 4, so maximum throughput is one instruction per 4 cycles.
  - A fault retires in cycle 2.
- Hazards: the WB write completes before the next instruction's DECODE, so back-to-back dependent instructions read the updated value with no forwarding.
- done, illegal and rf_we are never asserted outside WB/FAULT.

Test Plan:
- Reset then ADD:
  - Stimulus: x1=5, x2=7, instr=0x002081B3 (add x3,x1,x2).
  - Response: instr_ready falls after accept; alu_op=0, alu_a=5, alu_b=7 in cycle 2; cycle 3 rf_we=1, rf_waddr=3, rf_wdata=12, done=1; retire_cnt=1.
- SUB and SRAI:
  - sub x4,x1,x2 (0x40208233) → rf_wdata=0xFFFFFFFE.
  - srai x5,x4,1 (0x40125293) → alu_b=1, rf_wdata=0xFFFFFFFF; the dependent read sees the updated x4.
- ADDI negative immediate:
  - addi x6,x0,-1 (0xFFF00313) → alu_a=0, alu_b=0xFFFFFFFF, rf_wdata=0xFFFFFFFF.
  - The same with rd=0 → done=1, rf_we=0, retire_cnt still increments.
- Illegal instructions:
  - instr=0x00000003 (load) or R-type funct7=0000001 → cycle 2 done=1, illegal=1, rf_we=0, retire_cnt unchanged, instr_ready=1 in cycle 3.
- Handshake and reset:
  - Hold instr_valid high continuously → exactly one accept per 4 cycles.
  - Pull rst_n low during EXEC → outputs 0 immediately, no rf_we; after release the next instruction executes normally.
- Counter wrap: force retire_cnt=0xFFFFFFFF, then retire one ADD → retire_cnt=0.
